// File: rtl/bimodal_bp_pkg.sv
// Shared types and helpers for the bimodal branch direction predictor.
package bimodal_bp_pkg;

  // 2-bit saturating counter state; the MSB is the taken/not-taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = SNT;

  // Saturated next state: step toward ST on taken, toward SNT otherwise.
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    nxt = ctr;
    case (ctr)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = CTR_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bimodal_bp_sat_ctr.sv
// One table entry: a 2-bit saturating counter with synchronous reset.
module bimodal_sat_ctr
  import bimodal_bp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic taken,
  output ctr_t state
);

  // Reset wins over training; otherwise step once per enabled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CTR_RESET;
    end else if (en) begin
      state <= ctr_next(state, taken);
    end
  end

endmodule

// File: rtl/bimodal_bp.sv
// Bimodal branch predictor: direct-mapped table of 2-bit saturating counters
// indexed by the low PC bits. The same PC selects the entry that is read for
// the prediction and the entry that is trained, so a trained entry shows its
// pre-update value during the training cycle (no bypass).
module bimodal_bp
  import bimodal_bp_pkg::*;
#(
  parameter int PC_WIDTH   = 14,
  parameter int INDEX_BITS = 10   // must not exceed PC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch_en,
  input  logic                branch_result,
  input  logic [PC_WIDTH-1:0] PC,
  output logic                BP_decision
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [INDEX_BITS-1:0] idx;
  logic [ENTRIES-1:0]    wr_en;
  logic [1:0]            table_q [ENTRIES];
  logic [1:0]            sel_ctr;

  assign idx = PC[INDEX_BITS-1:0];

  // Upper PC bits alias onto the same entry; they are intentionally unused.
  if (PC_WIDTH > INDEX_BITS) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^PC[PC_WIDTH-1:INDEX_BITS];
  end

  // One-hot entry enable, fully gated by branch_en so an unknown PC with
  // branch_en low can never select an entry for update.
  always_comb begin
    wr_en = '0;
    if (branch_en) begin
      wr_en[idx] = 1'b1;
    end
  end

  // Flop-based table so the whole array clears in a single reset edge.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_table
    ctr_t entry_state;

    bimodal_sat_ctr u_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (wr_en[g]),
      .taken (branch_result),
      .state (entry_state)
    );

    assign table_q[g] = entry_state;
  end

  // Combinational read of the selected counter; prediction held low in reset.
  always_comb begin
    sel_ctr     = table_q[idx];
    BP_decision = rst ? 1'b0 : sel_ctr[1];
  end

endmodule

// File: tb/tb_bimodal_bp.sv
// Directed bench for bimodal_bp: a counter-array model checked every cycle,
// plus literal expectations at each directed step.
module tb_bimodal_bp;

  localparam int PC_WIDTH   = 14;
  localparam int INDEX_BITS = 10;
  localparam int ENTRIES    = 1 << INDEX_BITS;

  localparam logic [PC_WIDTH-1:0] PC_A     = 14'h00A;
  localparam logic [PC_WIDTH-1:0] PC_F     = 14'h01F;
  localparam logic [PC_WIDTH-1:0] PC_A_ALS = 14'h40A;
  localparam logic [PC_WIDTH-1:0] PC_TOP   = 14'h3FF;

  logic                clk;
  logic                rst;
  logic                branch_en;
  logic                branch_result;
  logic [PC_WIDTH-1:0] PC;
  logic                BP_decision;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bimodal_bp #(
    .PC_WIDTH   (PC_WIDTH),
    .INDEX_BITS (INDEX_BITS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .branch_en     (branch_en),
    .branch_result (branch_result),
    .PC            (PC),
    .BP_decision   (BP_decision)
  );

  // ---------------- behavioural model ----------------
  // Each entry is an integer 0..3; taken adds one up to 3, not-taken
  // subtracts one down to 0. Prediction is "counter >= 2".
  int model_ctr [ENTRIES];
  bit seen_rst = 1'b0;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      foreach (model_ctr[i]) model_ctr[i] <= 0;
      seen_rst <= 1'b1;
    end else if (branch_en === 1'b1) begin
      if (branch_result)
        model_ctr[PC % ENTRIES] <= (model_ctr[PC % ENTRIES] >= 3) ? 3 : model_ctr[PC % ENTRIES] + 1;
      else
        model_ctr[PC % ENTRIES] <= (model_ctr[PC % ENTRIES] <= 0) ? 0 : model_ctr[PC % ENTRIES] - 1;
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    logic exp_dec;
    if (seen_rst && !$isunknown(PC)) begin
      exp_dec = (rst === 1'b1) ? 1'b0 : (model_ctr[PC % ENTRIES] >= 2);
      checks++;
      if (BP_decision !== exp_dec) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t pc=%h got %b want %b", $time, PC, BP_decision, exp_dec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change just after the rising edge; they are sampled at the next one.
  task automatic step(input logic r, input logic e, input logic b, input logic [PC_WIDTH-1:0] pc);
    @(posedge clk);
    #1;
    rst           = r;
    branch_en     = e;
    branch_result = b;
    PC            = pc;
  endtask

  // Literal expectation for the value shown in the current cycle.
  task automatic lit(input string name, input logic exp_dec);
    #1;
    checks++;
    if (BP_decision !== exp_dec) begin
      errors++;
      $display("FAIL %s got %b want %b", name, BP_decision, exp_dec);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst           = 1'b1;
    branch_en     = 1'b0;
    branch_result = 1'b0;
    PC            = PC_A;
    #2;
    lit("in_reset", 1'b0);

    // Reset release: everything reads strongly not-taken.
    step(0, 0, 0, PC_A); lit("reset_a", 1'b0);
    step(0, 0, 0, PC_F); lit("reset_f", 1'b0);

    // Single-step: 00 -> 01 -> 00.
    step(0, 1, 1, PC_A); lit("single_up", 1'b0);
    step(0, 1, 0, PC_A); lit("single_mid", 1'b0);
    step(0, 0, 0, PC_A); lit("single_back", 1'b0);

    // Saturate up: values shown before each edge are 00,01,10,11,11.
    step(0, 1, 1, PC_A); lit("up0", 1'b0);
    step(0, 1, 1, PC_A); lit("up1", 1'b0);
    step(0, 1, 1, PC_A); lit("up2", 1'b1);
    step(0, 1, 1, PC_A); lit("up3", 1'b1);
    step(0, 1, 1, PC_A); lit("up4", 1'b1);
    step(0, 0, 0, PC_A); lit("up_hold", 1'b1);

    // Saturate down: shown values 11,10,01,00 then 00.
    step(0, 1, 0, PC_A); lit("dn0", 1'b1);
    step(0, 1, 0, PC_A); lit("dn1", 1'b1);
    step(0, 1, 0, PC_A); lit("dn2", 1'b0);
    step(0, 1, 0, PC_A); lit("dn3", 1'b0);
    step(0, 0, 0, PC_A); lit("dn_hold", 1'b0);

    // Independence: A to 11, F goes 01 -> 00, A still taken.
    step(0, 1, 1, PC_A); lit("ind_a0", 1'b0);
    step(0, 1, 1, PC_A); lit("ind_a1", 1'b0);
    step(0, 1, 1, PC_A); lit("ind_a2", 1'b1);
    step(0, 1, 1, PC_F); lit("ind_f0", 1'b0);
    step(0, 1, 0, PC_F); lit("ind_f1", 1'b0);
    step(0, 0, 0, PC_F); lit("ind_f2", 1'b0);
    step(0, 0, 0, PC_A); lit("ind_a_kept", 1'b1);

    // Aliasing: 0x40A shares entry 0x00A, both for reading and training.
    step(0, 0, 0, PC_A_ALS); lit("alias_read", 1'b1);
    step(0, 1, 0, PC_A_ALS); lit("alias_train", 1'b1);
    step(0, 0, 0, PC_A);     lit("alias_a_wt", 1'b1);
    step(0, 1, 0, PC_A);     lit("alias_a_dec", 1'b1);
    step(0, 0, 0, PC_A_ALS); lit("alias_wnt", 1'b0);
    step(0, 1, 1, PC_A);     lit("alias_a_inc", 1'b0);

    // Enable gating: taken with branch_en low for three edges changes nothing.
    step(0, 0, 1, PC_F); lit("gate0", 1'b0);
    step(0, 0, 1, PC_F); lit("gate1", 1'b0);
    step(0, 0, 1, PC_F); lit("gate2", 1'b0);
    step(0, 0, 0, PC_F); lit("gate_after", 1'b0);

    // Unknown PC with branch_en low must leave the table intact (A is 10).
    step(0, 0, 1, 'x);
    step(0, 0, 0, PC_A); lit("x_pc_safe", 1'b1);

    // Top entry of the table.
    step(0, 1, 1, PC_TOP); lit("top0", 1'b0);
    step(0, 1, 1, PC_TOP); lit("top1", 1'b0);
    step(0, 0, 0, PC_TOP); lit("top_taken", 1'b1);

    // Reset priority over training, then everything reads 00.
    step(1, 1, 1, PC_A);   lit("rst_force", 1'b0);
    step(0, 0, 0, PC_A);   lit("rst_clr_a", 1'b0);
    step(0, 0, 0, PC_TOP); lit("rst_clr_top", 1'b0);
    step(0, 1, 1, PC_A);   lit("post_rst0", 1'b0);
    step(0, 0, 0, PC_A);   lit("post_rst1", 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
